// File: rtl/sub_seq.sv
// sub_seq: 64-bit signed subtractor, diff = A - B, computed one nibble per
// clock (LSB first) through a 4-bit lookahead slice with a registered borrow
// chain. Latency is 17 cycles from the accepting edge to the done cycle.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - request; accepted in IDLE or DONE, ignored in RUN
//   A, B     - signed operands, sampled on the accepting edge
//   busy     - high while nibbles are being processed
//   done     - one-cycle pulse, result outputs valid
//   diff     - A - B modulo 2^64
//   overflow - signed overflow of A - B
//   zf, sf   - zero / sign flags of diff
//
// Build option: define SUB_SEQ_FLAGS_EN to compute zf/sf; otherwise both are
// tied to 0 and no flag logic exists.
module sub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic        busy,
  output logic        done,
  output logic [63:0] diff,
  output logic        overflow,
  output logic        zf,
  output logic        sf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [63:0] a_q, b_q, res;
  logic [3:0]  cnt;
  logic        c;
  logic        load, step, last;

  logic [3:0]  an, bn, g, p, s;
  logic [4:0]  cc;
  logic [63:0] fin;

  // Operands shift right each step, so the active nibble is always [3:0].
  always_comb begin
    an    = a_q[3:0];
    bn    = ~b_q[3:0];
    g     = an & bn;
    p     = an ^ bn;
    cc[0] = c;
    cc[1] = g[0] | (p[0] & c);
    cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c);
    s     = p ^ cc[3:0];
    // Result register fills from the top; on the last step this is the full word.
    fin   = {s, res[63:4]};
    last  = (cnt == 4'hF);
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res      <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      overflow <= 1'b0;
    end else begin
      busy <= (state_nx == RUN);
      done <= (state_nx == DONE);
      if (load) begin
        a_q <= A;
        b_q <= B;
        cnt <= '0;
        c   <= 1'b1;
      end else if (step) begin
        a_q <= a_q >> 4;
        b_q <= b_q >> 4;
        res <= fin;
        c   <= cc[4];
        cnt <= cnt + 4'd1;
        if (last) begin
          diff     <= fin;
          // cc[3]/cc[4] of nibble 15 are the carries into/out of bit 63.
          overflow <= cc[3] ^ cc[4];
        end
      end
    end
  end

`ifdef SUB_SEQ_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf <= 1'b0;
      sf <= 1'b0;
    end else if (step && last) begin
      zf <= (fin == '0);
      sf <= s[3];
    end
  end
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
`endif

endmodule

// File: tb/tb_sub_seq.sv
module tb_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] A, B;
  logic        busy, done, overflow, zf, sf;
  logic [63:0] diff;

  int n_checks = 0;
  int n_err    = 0;

  sub_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .diff(diff), .overflow(overflow),
    .zf(zf), .sf(sf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain two's-complement arithmetic and the sign rule for overflow.
  function automatic logic [63:0] m_diff(input logic [63:0] a, input logic [63:0] b);
    return a - b;
  endfunction

  function automatic logic m_ov(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] d;
    d = a - b;
    return (a[63] != b[63]) && (d[63] != a[63]);
  endfunction

  function automatic logic m_zf(input logic [63:0] a, input logic [63:0] b);
`ifdef SUB_SEQ_FLAGS_EN
    return (a == b);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_sf(input logic [63:0] a, input logic [63:0] b);
`ifdef SUB_SEQ_FLAGS_EN
    logic [63:0] d;
    d = a - b;
    return d[63];
`else
    return 1'b0;
`endif
  endfunction

  // Caller is at a negedge: drive a request for the next rising edge.
  task automatic launch(input logic [63:0] a, input logic [63:0] b);
    start = 1'b1;
    A     = a;
    B     = b;
  endtask

  // The next posedge is the accepting edge. Waits (bounded) for done,
  // checks latency and results, optionally re-requests in the done cycle.
  // inject > 0 drives a fresh start with A=B=1 at that RUN cycle.
  task automatic wait_done(input string tag, input logic [63:0] ea, input logic [63:0] eb,
                           input int inject, input bit b2b,
                           input logic [63:0] na, input logic [63:0] nb);
    int lat;
    bit busy_bad;
    lat = -1;
    busy_bad = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1 || i == inject + 1) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (i == inject) begin
        start = 1'b1;
        A = 64'd1;
        B = 64'd1;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'd17);
    chk({tag, "_busy_run"}, {63'd0, busy_bad}, 64'd0);
    chk({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    chk({tag, "_diff"}, diff, m_diff(ea, eb));
    chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, m_ov(ea, eb)});
    chk({tag, "_zf"}, {63'd0, zf}, {63'd0, m_zf(ea, eb)});
    chk({tag, "_sf"}, {63'd0, sf}, {63'd0, m_sf(ea, eb)});
    if (b2b) launch(na, nb);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb, pa, pb;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_diff", diff, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_zf", {63'd0, zf}, 64'd0);
    chk("rst_sf", {63'd0, sf}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(64'd5, 64'd3);
    wait_done("basic", 64'd5, 64'd3, 0, 1'b0, '0, '0);
    @(negedge clk);
    launch(64'h8000000000000000, 64'd1);
    wait_done("negovf", 64'h8000000000000000, 64'd1, 0, 1'b0, '0, '0);
    @(negedge clk);
    launch(64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    wait_done("posovf", 64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0, '0, '0);
    @(negedge clk);
    launch(64'h0123456789ABCDEF, 64'h0123456789ABCDEF);
    wait_done("zero", 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0, 1'b0, '0, '0);
    @(negedge clk);

    launch(64'd10, 64'd4);
    wait_done("ignore", 64'd10, 64'd4, 5, 1'b0, '0, '0);
    watch_quiet("ignore_single_done", 20);

    // Abort at RUN cycle 8; outputs must clear at once and no done follows.
    launch(64'd100, 64'd7);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_diff", diff, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_quiet("abort_no_done", 25);

    launch(64'd0, 64'd1);
    wait_done("neg1", 64'd0, 64'd1, 0, 1'b1, 64'd2, 64'd2);
    wait_done("b2b", 64'd2, 64'd2, 0, 1'b0, '0, '0);
    @(negedge clk);

    // Randomized back-to-back chain against the arithmetic model.
    pa = {$urandom, $urandom};
    pb = {$urandom, $urandom};
    launch(pa, pb);
    for (int k = 0; k < 12; k++) begin
      case (k % 4)
        0: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
        1: begin ra = {1'b1, 63'($urandom)}; rb = {1'b0, 31'($urandom), $urandom}; end
        2: begin ra = {$urandom, $urandom}; rb = ra; end
        default: begin ra = {1'b0, 31'($urandom), $urandom}; rb = {1'b1, 63'($urandom)}; end
      endcase
      wait_done("rand", pa, pb, 0, (k != 11), ra, rb);
      pa = ra;
      pb = rb;
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sub_seq.md
# sub_seq

Sequential 64-bit signed subtractor producing `diff = A - B` with Y86-style condition flags. It is the inverse-direction companion of the team's combinational 64-bit carry-lookahead adder. It processes one 4-bit nibble per clock, least-significant first, using a 4-bit lookahead slice and a registered inter-nibble borrow chain. It sits beside the ALU for multi-cycle compare/subtract paths where area matters more than latency.

## Interface
Parameters: none. Width is fixed at 64 bits in 16 nibbles.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst`  in  1  — reset, asynchronous, active-high.
- `start`  in  1  — request a subtraction; sampled only when accepted (see Operation).
- `A`  in  64  — signed minuend; sampled on the accepting edge.
- `B`  in  64  — signed subtrahend; sampled on the accepting edge.
- `busy`  out  1  — high while in RUN.
- `done`  out  1  — one-cycle pulse; results valid.
- `diff`  out  64  — signed result, two's complement, wraps modulo 2^64.
- `overflow`  out  1  — signed overflow of A − B.
- `zf`  out  1  — `diff == 0`.
- `sf`  out  1  — `diff[63]`.

## Operation
- **Arithmetic:** `diff = A + ~B + 1`. Carry-in of nibble 0 is 1.
- **Per-nibble step:** each RUN cycle k (0..15) adds `A_q[4k+3:4k] + ~B_q[4k+3:4k] + c`. It writes the sum nibble into an internal result register and registers the carry-out as `c` for nibble k+1.
- **Overflow:** in nibble 15, capture c63 (the carry into bit 63) and c64 (the carry out of bit 63). `overflow = c63 ^ c64`.
- **State machine:**
  - **IDLE:** `start` = 1 latches A and B, clears the nibble counter, sets c = 1, and moves to RUN.
  - **RUN:** processes one nibble per cycle. After nibble 15 it moves to DONE.
  - **DONE:** lasts exactly one cycle. `done` = 1, and the result register is copied to `diff`, `overflow`, `zf` and `sf`. If `start` = 1 in this cycle, new operands are latched and the next state is RUN. Otherwise the next state is IDLE.
- **Start while RUN:** ignored. Operands are not re-sampled and there is no error indication.
- **Output hold:** `diff`, `overflow`, `zf` and `sf` update only on entry to DONE. They hold their values through IDLE and through any subsequent RUN until the next DONE.
- **Reset values:** state = IDLE, `busy` = 0, `done` = 0, `diff` = 0, `overflow` = 0, `zf` = 0, `sf` = 0. Internal operand, counter and carry registers are cleared.
- **Reset mid-RUN:** the operation is aborted immediately (asynchronously) with all outputs at their reset values. No `done` pulse occurs for the aborted operation.

## Timing
- **Edge 0:** `start` is sampled high in IDLE. `busy` goes high after this edge.
- **Edges 1–16:** nibbles 0–15 are processed, one per edge. Edge 16 completes nibble 15 and enters DONE.
- **Cycle after edge 16:** `done` = 1, `busy` = 0, and outputs are valid. This gives 17 cycles of latency from the accepting edge to the `done` high cycle.
- **Back-to-back:** `start` asserted during the DONE cycle gives a throughput of one result per 17 cycles.
- **Timing of `busy` and `done`:** both are registered outputs. `busy` and `done` are never high simultaneously.

## Configuration
- **Macro `SUB_SEQ_FLAGS_EN`**
  - **Defined:** `zf` and `sf` are computed and registered as described above.
  - **Undefined:** `zf` and `sf` are tied to 0 and no flag logic is synthesized. `diff`, `overflow` and timing are unchanged.

## Test plan
- **Basic subtract:** A=5, B=3, `start` pulse. Expect `done` exactly 17 cycles after the accepting edge, `diff`=2, `overflow`=0, `zf`=0, `sf`=0.
- **Negative overflow:** A=0x8000000000000000, B=1. Expect `diff`=0x7FFFFFFFFFFFFFFF, `overflow`=1, `sf`=0.
- **Positive overflow:** A=0x7FFFFFFFFFFFFFFF, B=0xFFFFFFFFFFFFFFFF (−1). Expect `diff`=0x8000000000000000, `overflow`=1, `sf`=1. With `SUB_SEQ_FLAGS_EN` undefined, expect `sf`=0.
- **Zero result:** A=B=0x0123456789ABCDEF. Expect `diff`=0, `zf`=1, `overflow`=0.
- **Start ignored while RUN:** A=10, B=4. Re-assert `start` with A=1, B=1 at cycle 5 of RUN. Expect a single `done` at cycle 17 with `diff`=6.
- **Reset mid-RUN, then back-to-back:**
  - Assert `rst` at RUN cycle 8. Expect `busy`=0, `done`=0 and `diff`=0 immediately, with no `done` pulse afterwards.
  - After reset releases, start A=0, B=1. Expect `diff`=0xFFFFFFFFFFFFFFFF, `sf`=1.
  - Assert `start` in that DONE cycle with A=2, B=2. Expect the next `done` 17 cycles later with `zf`=1.
